// File: rtl/radix_4_intt_loader_pkg.sv
// rtl/radix_4_intt_loader_pkg.sv - shared constants and state encoding for the radix-4 INTT loader
package radix_4_intt_loader_pkg;

  // NTT modulus; coefficients are assumed already reduced below it
  localparam int Q = 65537;

  // Coefficient width, matches the butterfly PE LOGQ
  localparam int N = 17;

  // Coefficients per block (power of 4, at least 4)
  localparam int POINTS = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

endpackage

// File: rtl/radix_4_group_mux.sv
// rtl/radix_4_group_mux.sv - selects the four strided operands of butterfly group j
module radix_4_group_mux #(
  parameter int N      = 17,
  parameter int POINTS = 16,
  localparam int S     = POINTS / 4,
  localparam int IW    = (S > 1) ? $clog2(S) : 1
) (
  input  logic [POINTS-1:0][N-1:0] coefs,
  input  logic [IW-1:0]            sel,
  output logic [N-1:0]             grp_a,
  output logic [N-1:0]             grp_b,
  output logic [N-1:0]             grp_c,
  output logic [N-1:0]             grp_d
);

  localparam int PW = $clog2(POINTS);

  logic [PW-1:0] idx_a;
  logic [PW-1:0] idx_b;
  logic [PW-1:0] idx_c;
  logic [PW-1:0] idx_d;

  // sel < S, so j+3S stays at or below POINTS-1 and never wraps
  assign idx_a = PW'(sel);
  assign idx_b = idx_a + PW'(S);
  assign idx_c = idx_a + PW'(2 * S);
  assign idx_d = idx_a + PW'(3 * S);

  assign grp_a = coefs[idx_a];
  assign grp_b = coefs[idx_b];
  assign grp_c = coefs[idx_c];
  assign grp_d = coefs[idx_d];

endmodule

// File: rtl/radix_4_intt_loader.sv
// rtl/radix_4_intt_loader.sv - buffers one coefficient block and issues radix-4 butterfly groups
module radix_4_intt_loader #(
  parameter int N      = radix_4_intt_loader_pkg::N,
  parameter int POINTS = radix_4_intt_loader_pkg::POINTS,
  localparam int S     = POINTS / 4,
  localparam int IW    = (S > 1) ? $clog2(S) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_a,
  output logic [N-1:0]  out_b,
  output logic [N-1:0]  out_c,
  output logic [N-1:0]  out_d,
  output logic [IW-1:0] out_tf_idx,
  output logic          busy,
  output logic          done
);

  import radix_4_intt_loader_pkg::*;

  localparam int CW = $clog2(POINTS);
  localparam logic [CW-1:0] LAST_IDX = CW'(POINTS - 1);
  localparam logic [IW-1:0] LAST_J   = IW'(S - 1);

  logic [1:0]               state_q;
  logic [1:0]               state_d;
  logic [CW-1:0]            cnt_q;
  logic [IW-1:0]            j_q;
  logic [IW-1:0]            sel;
  logic [POINTS-1:0][N-1:0] coef_q;
  logic [POINTS-1:0][N-1:0] coef_d;
  logic [N-1:0]             grp_a;
  logic [N-1:0]             grp_b;
  logic [N-1:0]             grp_c;
  logic [N-1:0]             grp_d;
  logic                     in_fire;
  logic                     last_word;
  logic                     out_fire;
  logic                     last_group;

  assign in_fire    = in_valid && in_ready;
  assign last_word  = in_fire && (state_q == LOAD) && (cnt_q == LAST_IDX);
  assign out_fire   = out_valid && out_ready;
  assign last_group = out_fire && (j_q == LAST_J);

  // Group to register next: group 0 when the block completes, j+1 while issuing
  assign sel = ((state_q == ISSUE) && (j_q != LAST_J)) ? j_q + IW'(1) : '0;

  // Buffer view with the word accepted this cycle already written, so the last
  // word reaches the first group without an extra cycle
  always_comb begin
    coef_d = coef_q;
    if (in_fire) begin
      coef_d[cnt_q] = in_data;
    end
  end

  // Coefficient storage, contents are don't-care after reset
  always_ff @(posedge clk) begin
    coef_q <= coef_d;
  end

  radix_4_group_mux #(
    .N      (N),
    .POINTS (POINTS)
  ) u_group_mux (
    .coefs (coef_d),
    .sel   (sel),
    .grp_a (grp_a),
    .grp_b (grp_b),
    .grp_c (grp_c),
    .grp_d (grp_d)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire)    state_d = LOAD;
      LOAD:    if (last_word)  state_d = ISSUE;
      ISSUE:   if (last_group) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state_q == IDLE) || (state_q == LOAD);
    busy     = (state_q == LOAD) || (state_q == ISSUE);
  end

  // Load counter and group index, both cleared explicitly at block boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      j_q   <= '0;
    end else begin
      if (last_word) begin
        cnt_q <= '0;
      end else if (in_fire) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (last_word || last_group) begin
        j_q <= '0;
      end else if (out_fire) begin
        j_q <= j_q + IW'(1);
      end
    end
  end

  // Registered group outputs, held stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_c      <= '0;
      out_d      <= '0;
      out_tf_idx <= '0;
      done       <= 1'b0;
    end else begin
      done <= last_group;
      if (last_word || (out_fire && !last_group)) begin
        out_valid  <= 1'b1;
        out_a      <= grp_a;
        out_b      <= grp_b;
        out_c      <= grp_c;
        out_d      <= grp_d;
        out_tf_idx <= sel;
      end else if (last_group) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_radix_4_intt_loader.sv
// tb/tb_radix_4_intt_loader.sv - randomized self-checking bench for the radix-4 INTT loader
module tb_radix_4_intt_loader;

  localparam int N      = 17;
  localparam int POINTS = 16;
  localparam int S      = 4;
  localparam int IW     = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_a;
  logic [N-1:0]  out_b;
  logic [N-1:0]  out_c;
  logic [N-1:0]  out_d;
  logic [IW-1:0] out_tf_idx;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] blk [POINTS];

  radix_4_intt_loader #(
    .N      (N),
    .POINTS (POINTS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .out_tf_idx (out_tf_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Feeds blk[] and consumes groups; expected group j is
  // (blk[j], blk[j+S], blk[j+2S], blk[j+3S]) with twiddle index j.
  // Entered and left just after a rising edge.
  task automatic run_block(input int gap_pct, input int stall_pct, input int hold_grp);
    int ni = 0;
    int ng = 0;
    int held = 0;
    int budget = 0;
    while (ng < S && budget < 600) begin
      if (ni < POINTS) begin
        in_valid = ($urandom_range(99) >= gap_pct);
        in_data  = blk[ni];
      end else begin
        in_valid = $urandom_range(1);
        in_data  = N'($urandom);
      end
      if (ni == POINTS && ng == hold_grp && held < 3) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      @(negedge clk);
      check("in_ready", in_ready, ni < POINTS);
      check("busy", busy, ni > 0);
      check("done_early", done, 1'b0);
      check("out_valid", out_valid, ni == POINTS);
      if (ni == POINTS) begin
        check("out_a", out_a, blk[ng]);
        check("out_b", out_b, blk[ng + S]);
        check("out_c", out_c, blk[ng + 2*S]);
        check("out_d", out_d, blk[ng + 3*S]);
        check("out_tf_idx", out_tf_idx, ng);
      end
      if (ni < POINTS) begin
        if (in_valid) ni++;
      end else if (out_ready) begin
        ng++;
      end
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 600) check("timeout_groups", ng, S);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("in_ready_after", in_ready, 1'b1);
    check("busy_after", busy, 1'b0);
    check("out_valid_after", out_valid, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("done_single", done, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_a", out_a, 0);
    check("rst_out_d", out_d, 0);
    check("rst_tf_idx", out_tf_idx, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back load, consumer always ready
    for (int i = 0; i < POINTS; i++) blk[i] = N'(100 + i);
    run_block(0, 0, -1);

    // Consumer stalls three cycles on group 1
    run_block(0, 0, 1);

    // Gappy input stream
    run_block(50, 0, -1);

    // Reset in the middle of loading
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = N'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_a", out_a, 0);
    check("arst_out_b", out_b, 0);
    check("arst_out_c", out_c, 0);
    check("arst_out_d", out_d, 0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < POINTS; i++) blk[i] = N'(i);
    run_block(0, 0, -1);

    // Second block with stalls and in_valid noise during issue
    for (int i = 0; i < POINTS; i++) blk[i] = N'(200 + i);
    run_block(0, 30, -1);

    // Full-width value in every slot
    for (int i = 0; i < POINTS; i++) blk[i] = N'(17'h10000);
    run_block(20, 20, -1);

    // Random blocks
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < POINTS; i++) blk[i] = N'($urandom);
      run_block(30, 30, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/radix_4_intt_loader.md
Name: radix_4_intt_loader

Overview:
- Upstream feeder for the radix-4 INTT butterfly PE.
- Collects one block of POINTS coefficients, arriving serially one per handshake, into an internal register buffer.
- Then issues POINTS/4 butterfly groups {j, j+S, j+2S, j+3S}, where S = POINTS/4, as four parallel operands plus a twiddle index, over a valid/ready handshake.
- Sits between the coefficient stream source and the combinational PE plus twiddle ROM.

Parameters:
- N, 17, coefficient width in bits (matches PE LOGQ).
- POINTS, 16, coefficients per block; power of 4, minimum 4.
- S (localparam), POINTS/4, butterfly stride and group count.
- IW (localparam), max(1, clog2(S)), twiddle index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a coefficient.
- in_data  in  N  coefficient, natural order, value < Q (not checked).
- out_valid  out  1  out_a..out_d and out_tf_idx valid.
- out_ready  in  1  consumer accepts the current group.
- out_a  out  N  buf[j].
- out_b  out  N  buf[j+S].
- out_c  out  N  buf[j+2S].
- out_d  out  N  buf[j+3S].
- out_tf_idx  out  IW  group index j, used as the twiddle ROM address.
- busy  out  1  high in LOAD or ISSUE.
- done  out  1  one-cycle pulse on acceptance of the last group.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, load count=0, j=0, out_valid=0, out_a..out_d=0, out_tf_idx=0, done=0, busy=0. Buffer contents are not reset (don't-care).
- State IDLE:
  - in_ready=1.
  - On in_valid: write buf[0], count=1, go to LOAD.
  - POINTS is at least 4, so a single-word block never occurs.
- State LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready writes buf[count] and increments count.
  - When the accepted word is index POINTS-1, go to ISSUE on the next edge. On that same edge, register out_a..out_d = buf[0], buf[S], buf[2S], buf[3S]; out_tf_idx=0; out_valid=1.
  - The last word is forwarded: out_d takes in_data directly when POINTS-1 == 3S.
  - Latency: last input accepted in cycle t gives out_valid=1 in cycle t+1.
  - Gaps (in_valid=0) hold state and count.
- State ISSUE:
  - in_ready=0; in_valid is ignored.
  - Outputs are registered and must stay stable while out_valid && !out_ready.
  - On out_valid&&out_ready with j<S-1: j increments, and the next group is registered on the same edge. out_valid stays 1, so there are no bubbles: one group per cycle under continuous out_ready.
  - On out_valid&&out_ready with j=S-1:
    - done=1 for exactly the next cycle.
    - out_valid=0, j=0, count=0, state=IDLE.
    - in_ready=1 from that next cycle, so a new block may start one cycle after the final group handshake.
- busy=1 whenever state is LOAD or ISSUE.
- Reset asserted mid-LOAD or mid-ISSUE aborts the block immediately. No partial done. The next block starts from index 0.
- Indices never wrap past POINTS-1; count and j are sized and terminated explicitly.
- No arithmetic on data; values pass through bit-exact.

Decomposition:
- Shared package holds:
  - the NTT modulus Q;
  - coefficient width N;
  - POINTS;
  - a state encoding localparam set (IDLE=2'd0, LOAD=2'd1, ISSUE=2'd2).
- One natural sub-module, radix_4_group_mux: combinational selection of buf[j], buf[j+S], buf[j+2S], buf[j+3S] from the flat buffer, given j.
- The FSM, counters and output registers stay in the top module.

Test Plan (N=17, POINTS=16, S=4):
- Load data 100..115 back-to-back with out_ready=1:
  - out_valid rises the cycle after word 115 is accepted.
  - Groups are (100,104,108,112) idx0, (101,105,109,113) idx1, (102,106,110,114) idx2, (103,107,111,115) idx3 on consecutive cycles.
  - done pulses once; in_ready=1 the following cycle.
- Same load with out_ready held 0 for 3 cycles at group 1: group 1 outputs and idx=1 stay stable; no group is skipped or repeated; done arrives after the 4th handshake.
- Load with in_valid toggling every other cycle: the same 16 words are captured in order; in_ready stays 1 throughout LOAD; the output groups are identical to the first test.
- rst_n pulsed low after 7 words loaded:
  - outputs go to 0 asynchronously; busy=0.
  - A fresh load 0..15 then yields (0,4,8,12) first; no done before that block completes.
- Two blocks back-to-back (second block 200..215):
  - in_valid asserted during ISSUE is not accepted (in_ready=0).
  - Second block groups begin with (200,204,208,212).
- Data 65536 (0x10000) in all slots: all outputs are 65536 bit-exact, confirming no truncation at full N=17 width.
